ps2_cmd_sequencer: RTL
======================

// Module: ps2_cmd_sequencer
// PURPOSE
//  Host-to-device command scheduler for the PS/2 port. Accepts one command byte at a time,
//  hands it to the PS/2 transmitter (wr_en/wr_data/wr_done), then waits for the device ACK.
//  The ACK comes back as a byte on the PS/2 receiver's rx_valid/rx_data strobe.
//  Retries on Resend or timeout. Sits between the mouse/keyboard driver logic and ps2_tx/ps2_rx.
// PARAMETERS
//  ACK_TO_CYC  1_000_000  clk_sys cycles to wait for a response after wr_done (20 ms @ 50 MHz)
//  MAX_RETRY   3          resends allowed per command before cmd_err
// PORTS
//  clk_sys     in   1  50 MHz system clock
//  rst_n       in   1  asynchronous active-low reset
//  cmd_valid   in   1  command request
//  cmd_byte    in   8  command byte to send
//  cmd_ready   out  1  sequencer idle, command accepted on cmd_valid&cmd_ready
//  cmd_done    out  1  1-cycle pulse: ACK (0xFA) received
//  cmd_err     out  1  1-cycle pulse: retries exhausted or error response (0xFC)
//  busy        out  1  high from acceptance until cmd_done/cmd_err
//  tx_wr_en    out  1  1-cycle pulse to ps2_tx
//  tx_wr_data  out  8  byte to ps2_tx, stable from tx_wr_en until tx_wr_done
//  tx_wr_done  in   1  ps2_tx completion pulse
//  rx_valid    in   1  ps2_rx byte strobe
//  rx_data     in   8  received byte
//  init_done   out  1  boot sequence complete (see CONFIGURATION)
// BEHAVIOUR
//  Clock/reset: one clock clk_sys; rst_n asynchronous, active-low.
//  Reset values: cmd_done=cmd_err=busy=tx_wr_en=0, tx_wr_data=8'h00, counters 0, state IDLE.
//  States: IDLE -> LOAD -> WAIT_TX -> WAIT_ACK -> (IDLE | LOAD on retry).
//  IDLE: cmd_ready=1. On cmd_valid, latch cmd_byte and clear retry_cnt -> LOAD.
//  LOAD: tx_wr_en=1 for exactly one cycle -> WAIT_TX. Accept at N => tx_wr_en at N+1.
//  WAIT_TX: hold tx_wr_data. On tx_wr_done, load to_cnt=ACK_TO_CYC-1 -> WAIT_ACK.
//   rx_valid in this state is ignored.
//  WAIT_ACK: to_cnt decrements each cycle. On rx_valid:
//   - rx_data 0xFA: cmd_done pulse next cycle -> IDLE.
//   - 0xFE: retry.
//   - 0xFC: cmd_err pulse -> IDLE.
//   - any other byte: ignored (stream data), timer keeps running.
//   to_cnt==0 with no rx_valid: timeout, treated as retry. rx_valid wins over timeout in the same cycle.
//  Retry: if retry_cnt<MAX_RETRY, retry_cnt++ -> LOAD with the same byte.
//   Otherwise cmd_err pulse -> IDLE. MAX_RETRY=3 gives 4 total transmissions.
//  cmd_done and cmd_err are never high together. cmd_ready=0 whenever busy=1.
//   cmd_valid while busy is not latched; the requester holds it.
//  Widths: to_cnt $clog2(ACK_TO_CYC+1) bits; retry_cnt $clog2(MAX_RETRY+1) bits; no wrap.
//  Reset mid-operation: immediate return to reset values. A byte partly sent by ps2_tx is abandoned.
// CONFIGURATION
//  PS2_BOOT_INIT_EN defined:
//   - After reset, run BOOT before IDLE: send 0xFF, expect 0xFA, then BAT 0xAA and ID 0x00.
//     Each expected byte uses the same ACK_TO_CYC timeout and retry rules.
//   - Then send 0xF4 and expect 0xFA.
//   - init_done rises and stays 1. Boot failure: cmd_err pulse and restart of the boot sequence.
//   - cmd_ready=0 until init_done=1.
//  Not defined: no BOOT state; init_done=1 from the first cycle after reset release.
// STRUCTURE
//  ps2_pkg:
//   - state enum typedef.
//   - Constants PS2_CMD_RESET=8'hFF, PS2_CMD_STREAM_EN=8'hF4, PS2_RSP_ACK=8'hFA,
//     PS2_RSP_RESEND=8'hFE, PS2_RSP_ERR=8'hFC, PS2_RSP_BAT_OK=8'hAA, PS2_RSP_ID=8'h00.
//  One sub-module: ps2_ack_timer. Loadable down-counter with load/expire, parameter ACK_TO_CYC.
//  Boot sequence is a constant ROM of {byte, expect} entries inside the sequencer, not a separate module.
// TESTING
//  1 cmd 0xF4 accepted, tx_wr_done after 100 cyc, rx 0xFA after 500 cyc
//    -> one tx_wr_en (data 0xF4); cmd_done 1 cyc after rx_valid; busy low next.
//  2 cmd 0xF3, device answers 0xFE twice then 0xFA -> 3 tx_wr_en pulses with 0xF3; cmd_done; no cmd_err.
//  3 cmd 0xE8, no response (ACK_TO_CYC=1000) -> 4 tx_wr_en at ~1000-cyc spacing; then cmd_err pulse.
//  4 WAIT_ACK gets rx 0x08 then 0xFA -> 0x08 ignored, cmd_done; rx 0xFC instead -> cmd_err, no retry.
//  5 rst_n low during WAIT_TX -> all outputs at reset values; new cmd after release runs normally.
//  6 PS2_BOOT_INIT_EN: device replies FA, AA, 00, then FA to the 0xF4
//    -> tx bytes FF then F4; init_done=1; cmd_ready=0 before that.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and PS/2 protocol constants for the host-to-device command sequencer.
// The boot ROM contents live here so the sequencer can index them by position.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BOOT,
    ST_LOAD,
    ST_WAIT_TX,
    ST_WAIT_ACK
  } state_t;

  localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
  localparam logic [7:0] PS2_CMD_STREAM_EN = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK       = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND    = 8'hFE;
  localparam logic [7:0] PS2_RSP_ERR       = 8'hFC;
  localparam logic [7:0] PS2_RSP_BAT_OK    = 8'hAA;
  localparam logic [7:0] PS2_RSP_ID        = 8'h00;

  // send=0 entries only wait for a byte the device volunteers (BAT result, device ID)
  typedef struct packed {
    logic       send;
    logic [7:0] tx_byte;
    logic [7:0] rsp_byte;
  } boot_entry_t;

  localparam int BOOT_LEN = 4;

  function automatic boot_entry_t boot_rom(input logic [1:0] idx);
    boot_entry_t e;
    case (idx)
      2'd0:    e = {1'b1, PS2_CMD_RESET, PS2_RSP_ACK};
      2'd1:    e = {1'b0, 8'h00, PS2_RSP_BAT_OK};
      2'd2:    e = {1'b0, 8'h00, PS2_RSP_ID};
      default: e = {1'b1, PS2_CMD_STREAM_EN, PS2_RSP_ACK};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ps2_ack_timer.sv
// Loadable down-counter bounding the wait for a device response.
// expire is high while the count sits at zero; the count never wraps.
module ps2_ack_timer #(
  parameter int ACK_TO_CYC = 1_000_000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(ACK_TO_CYC + 1);

  logic [CW-1:0] to_cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (load) begin
      to_cnt <= CW'(ACK_TO_CYC - 1);
    end else if (run && (to_cnt != '0)) begin
      to_cnt <= to_cnt - 1'b1;
    end
  end

  assign expire = (to_cnt == '0);

endmodule

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command scheduler: send a byte, wait for ACK, retry on Resend/timeout.
// Define PS2_BOOT_INIT_EN to run the reset/enable boot sequence before accepting commands.
module ps2_cmd_sequencer
  import ps2_pkg::*;
#(
  parameter int ACK_TO_CYC = 1_000_000,
  parameter int MAX_RETRY  = 3
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  output logic       cmd_ready,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic       busy,
  output logic       tx_wr_en,
  output logic [7:0] tx_wr_data,
  input  logic       tx_wr_done,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       init_done
);

`ifdef PS2_BOOT_INIT_EN
  localparam bit     BOOT_EN   = 1'b1;
  localparam state_t RST_STATE = ST_BOOT;
`else
  localparam bit     BOOT_EN   = 1'b0;
  localparam state_t RST_STATE = ST_IDLE;
`endif

  localparam int            RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  state_t        state_q, state_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    boot_idx_q, boot_idx_d;
  logic          init_q, init_d;
  logic          timer_load, timer_run, timer_expire;
  logic          boot_mode;
  boot_entry_t   entry;
  logic [7:0]    exp_rsp;
  logic          rsp_ok, rsp_retry, rsp_fail;

  assign boot_mode = BOOT_EN && !init_q;
  assign entry     = boot_rom(boot_idx_q);
  assign exp_rsp   = boot_mode ? entry.rsp_byte : PS2_RSP_ACK;

  ps2_ack_timer #(
    .ACK_TO_CYC(ACK_TO_CYC)
  ) u_ack_timer (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .load    (timer_load),
    .run     (timer_run),
    .expire  (timer_expire)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      tx_byte_q  <= 8'h00;
      retry_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      boot_idx_q <= '0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      retry_q    <= retry_d;
      done_q     <= done_d;
      err_q      <= err_d;
      boot_idx_q <= boot_idx_d;
      init_q     <= init_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_byte_d  = tx_byte_q;
    retry_d    = retry_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    boot_idx_d = boot_idx_q;
    init_d     = init_q | !BOOT_EN;
    timer_load = 1'b0;
    timer_run  = 1'b0;
    tx_wr_en   = 1'b0;
    cmd_ready  = 1'b0;
    rsp_ok     = 1'b0;
    rsp_retry  = 1'b0;
    rsp_fail   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = init_q;
        if (cmd_valid && init_q) begin
          tx_byte_d = cmd_byte;
          retry_d   = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_BOOT: begin
        retry_d = '0;
        if (entry.send) begin
          tx_byte_d = entry.tx_byte;
          state_d   = ST_LOAD;
        end else begin
          timer_load = 1'b1;
          state_d    = ST_WAIT_ACK;
        end
      end
      ST_LOAD: begin
        tx_wr_en = 1'b1;
        state_d  = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_wr_done) begin
          timer_load = 1'b1;
          state_d    = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        timer_run = 1'b1;
        // A byte arriving on the expiry cycle takes precedence over the timeout
        if (rx_valid) begin
          if (rx_data == exp_rsp)             rsp_ok    = 1'b1;
          else if (rx_data == PS2_RSP_RESEND) rsp_retry = 1'b1;
          else if (rx_data == PS2_RSP_ERR)    rsp_fail  = 1'b1;
        end else if (timer_expire) begin
          rsp_retry = 1'b1;
        end

        if (rsp_retry) begin
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 1'b1;
            if (boot_mode && !entry.send) timer_load = 1'b1;
            else                          state_d    = ST_LOAD;
          end else begin
            rsp_fail = 1'b1;
          end
        end

        if (rsp_ok) begin
          if (!boot_mode) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (boot_idx_q == 2'(BOOT_LEN - 1)) begin
            init_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            boot_idx_d = boot_idx_q + 1'b1;
            state_d    = ST_BOOT;
          end
        end

        // A failed boot step restarts the whole sequence from the reset command
        if (rsp_fail) begin
          err_d = 1'b1;
          if (boot_mode) begin
            boot_idx_d = '0;
            state_d    = ST_BOOT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy       = init_q && (state_q != ST_IDLE);
  assign cmd_done   = done_q;
  assign cmd_err    = err_q;
  assign tx_wr_data = tx_byte_q;
  assign init_done  = init_q;

endmodule
